// File: rtl/sd_sec_read_arbiter.sv
// Shares one SD-card sector-read engine between two requesters.
// Whole-sector transactions are serialised with round-robin fairness; read
// data, valid and end strobes are routed back only to the current owner.
// A watchdog releases the engine if a sector read never completes.
//
//   state | meaning
//   IDLE  | engine free, arbitrate between pending requests
//   GRANT | one port owns the engine, sd_sec_read held high
//   GAP   | one-cycle low on sd_sec_read so the controller sees a new edge
module sd_sec_read_arbiter #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd5_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sd_init_done,

  input  logic        req0_sec_read,
  input  logic [31:0] req0_sec_read_addr,
  output logic [7:0]  req0_sec_read_data,
  output logic        req0_sec_read_data_valid,
  output logic        req0_sec_read_end,

  input  logic        req1_sec_read,
  input  logic [31:0] req1_sec_read_addr,
  output logic [7:0]  req1_sec_read_data,
  output logic        req1_sec_read_data_valid,
  output logic        req1_sec_read_end,

  output logic        sd_sec_read,
  output logic [31:0] sd_sec_read_addr,
  input  logic [7:0]  sd_sec_read_data,
  input  logic        sd_sec_read_data_valid,
  input  logic        sd_sec_read_end,

  output logic [1:0]  grant,
  output logic        timeout_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]  state;
  logic        last_grant;   // index of the port served most recently
  logic [31:0] watchdog;
  logic [1:0]  winner;
  logic        timeout_hit;

  // Round-robin pick: on a tie the port that was not served last wins.
  always_comb begin
    winner = 2'b00;
    if (req0_sec_read && req1_sec_read)
      winner = last_grant ? 2'b01 : 2'b10;
    else if (req0_sec_read)
      winner = 2'b01;
    else if (req1_sec_read)
      winner = 2'b10;
  end

  // Watchdog abort; a real end on the limit cycle takes precedence, and an
  // engine being torn down by sd_init_done never reports a timeout.
  always_comb begin
    timeout_hit = (state == ST_GRANT) && sd_init_done && !sd_sec_read_end &&
                  (watchdog == TIMEOUT_CYCLES - 32'd1);
  end

  assign timeout_err = timeout_hit;

  // Arbitration FSM, engine request, latched address and watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      last_grant       <= 1'b1;
      watchdog         <= 32'd0;
      sd_sec_read      <= 1'b0;
      sd_sec_read_addr <= 32'd0;
      grant            <= 2'b00;
    end else if (!sd_init_done) begin
      state       <= ST_IDLE;
      sd_sec_read <= 1'b0;
      grant       <= 2'b00;
      watchdog    <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (winner != 2'b00) begin
            state            <= ST_GRANT;
            grant            <= winner;
            sd_sec_read      <= 1'b1;
            sd_sec_read_addr <= winner[1] ? req1_sec_read_addr : req0_sec_read_addr;
            watchdog         <= 32'd0;
          end
        end
        ST_GRANT: begin
          if (sd_sec_read_end || timeout_hit) begin
            state       <= ST_GAP;
            sd_sec_read <= 1'b0;
            grant       <= 2'b00;
            last_grant  <= grant[1];
          end else if (watchdog != 32'hFFFF_FFFF) begin
            watchdog <= watchdog + 32'd1;
          end
        end
        ST_GAP: begin
          state <= ST_IDLE;
        end
        default: begin
          state       <= ST_IDLE;
          sd_sec_read <= 1'b0;
          grant       <= 2'b00;
        end
      endcase
    end
  end

  // Return path, gated so only the owner ever sees engine activity.
  always_comb begin
    req0_sec_read_data       = grant[0] ? sd_sec_read_data : 8'd0;
    req1_sec_read_data       = grant[1] ? sd_sec_read_data : 8'd0;
    req0_sec_read_data_valid = grant[0] & sd_sec_read_data_valid;
    req1_sec_read_data_valid = grant[1] & sd_sec_read_data_valid;
    req0_sec_read_end        = grant[0] & (sd_sec_read_end | timeout_hit);
    req1_sec_read_end        = grant[1] & (sd_sec_read_end | timeout_hit);
  end

endmodule

// File: tb/tb_sd_sec_read_arbiter.sv
// Scoreboard bench for sd_sec_read_arbiter: expected grants (port, address)
// are queued as requests are raised and checked as the engine is claimed.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// (registered) or 1 ns after an input change (combinational routing).
module tb_sd_sec_read_arbiter;

  localparam logic [31:0] TO = 32'd640;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sd_init_done = 1'b1;
  logic        req0_sec_read = 1'b0, req1_sec_read = 1'b0;
  logic [31:0] req0_sec_read_addr = 32'd0, req1_sec_read_addr = 32'd0;
  logic [7:0]  req0_sec_read_data, req1_sec_read_data;
  logic        req0_sec_read_data_valid, req1_sec_read_data_valid;
  logic        req0_sec_read_end, req1_sec_read_end;
  logic        sd_sec_read;
  logic [31:0] sd_sec_read_addr;
  logic [7:0]  sd_sec_read_data = 8'd0;
  logic        sd_sec_read_data_valid = 1'b0;
  logic        sd_sec_read_end = 1'b0;
  logic [1:0]  grant;
  logic        timeout_err;

  int n_checks = 0;
  int n_fail   = 0;
  int          exp_port_q[$];
  logic [31:0] exp_addr_q[$];
  int          cur_port = 0;

  sd_sec_read_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .sd_init_done(sd_init_done),
    .req0_sec_read(req0_sec_read), .req0_sec_read_addr(req0_sec_read_addr),
    .req0_sec_read_data(req0_sec_read_data),
    .req0_sec_read_data_valid(req0_sec_read_data_valid),
    .req0_sec_read_end(req0_sec_read_end),
    .req1_sec_read(req1_sec_read), .req1_sec_read_addr(req1_sec_read_addr),
    .req1_sec_read_data(req1_sec_read_data),
    .req1_sec_read_data_valid(req1_sec_read_data_valid),
    .req1_sec_read_end(req1_sec_read_end),
    .sd_sec_read(sd_sec_read), .sd_sec_read_addr(sd_sec_read_addr),
    .sd_sec_read_data(sd_sec_read_data),
    .sd_sec_read_data_valid(sd_sec_read_data_valid),
    .sd_sec_read_end(sd_sec_read_end),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int port, input logic [31:0] addr);
    exp_port_q.push_back(port);
    exp_addr_q.push_back(addr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_sd_read", sd_sec_read, 0);
    check("rst_grant", grant, 0);
    check("rst_addr", sd_sec_read_addr, 0);
    check("rst_tmo", timeout_err, 0);
    check("rst_req_out", {req0_sec_read_data, req1_sec_read_data, req0_sec_read_data_valid,
          req1_sec_read_data_valid, req0_sec_read_end, req1_sec_read_end}, 0);
    exp_port_q.delete();
    exp_addr_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait for the engine to be claimed; exp_low < 0 skips the gap-length check.
  task automatic wait_grant(input int exp_low);
    int n = 0;
    @(negedge clk);
    while (!sd_sec_read && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!sd_sec_read) begin
      check("grant_wait", 0, 1);
      return;
    end
    if (exp_low >= 0) check("low_cycles", n, exp_low);
    if (exp_port_q.size() == 0) begin
      check("sb_empty", 1, 0);
      return;
    end
    cur_port = exp_port_q.pop_front();
    check("grant", grant, (cur_port == 1) ? 2'b10 : 2'b01);
    check("addr", sd_sec_read_addr, exp_addr_q.pop_front());
  endtask

  task automatic stream(input int n);
    logic [7:0] own_d, oth_d;
    logic       own_v, oth_v;
    for (int i = 0; i < n; i++) begin
      sd_sec_read_data = 8'($urandom);
      sd_sec_read_data_valid = 1'b1;
      #1;
      own_d = cur_port ? req1_sec_read_data : req0_sec_read_data;
      oth_d = cur_port ? req0_sec_read_data : req1_sec_read_data;
      own_v = cur_port ? req1_sec_read_data_valid : req0_sec_read_data_valid;
      oth_v = cur_port ? req0_sec_read_data_valid : req1_sec_read_data_valid;
      check("own_data", own_d, sd_sec_read_data);
      check("own_valid", own_v, 1);
      check("oth_data", oth_d, 0);
      check("oth_valid", oth_v, 0);
      @(negedge clk);
    end
    sd_sec_read_data_valid = 1'b0;
  endtask

  // End strobe from the controller; returns at the falling edge of GAP.
  task automatic finish_end();
    sd_sec_read_end = 1'b1;
    sd_sec_read_data_valid = 1'b0;
    #1;
    check("own_end", cur_port ? req1_sec_read_end : req0_sec_read_end, 1);
    check("oth_end", cur_port ? req0_sec_read_end : req1_sec_read_end, 0);
    check("end_no_tmo", timeout_err, 0);
    @(negedge clk);
    sd_sec_read_end = 1'b0;
    check("gap_sd_read", sd_sec_read, 0);
    check("gap_grant", grant, 0);
    sd_sec_read_data = 8'h5A;
    sd_sec_read_data_valid = 1'b1;
    #1;
    check("gap_valid_blocked", {req0_sec_read_data_valid, req1_sec_read_data_valid}, 0);
    check("gap_data_blocked", {req0_sec_read_data, req1_sec_read_data}, 0);
    sd_sec_read_data_valid = 1'b0;
  endtask

  task automatic watchdog_abort();
    bit early = 0;
    for (int k = 1; k < int'(TO); k++) begin
      #1;
      if (timeout_err || req0_sec_read_end || req1_sec_read_end) early = 1;
      @(negedge clk);
    end
    check("tmo_early", early, 0);
    #1;
    check("tmo_pulse", timeout_err, 1);
    check("tmo_own_end", cur_port ? req1_sec_read_end : req0_sec_read_end, 1);
    check("tmo_oth_end", cur_port ? req0_sec_read_end : req1_sec_read_end, 0);
    @(negedge clk);
    check("tmo_sd_read", sd_sec_read, 0);
    check("tmo_grant", grant, 0);
    check("tmo_one_cycle", timeout_err, 0);
  endtask

  initial begin
    do_reset();

    // Single requester, full 512-byte sector.
    req0_sec_read = 1'b1;
    req0_sec_read_addr = 32'd8196;
    push_exp(0, 32'd8196);
    wait_grant(0);
    stream(512);
    finish_end();
    req0_sec_read = 1'b0;
    @(negedge clk);
    check("idle_after", sd_sec_read, 0);

    // Both ports contending from reset: strict alternation starting with 0.
    do_reset();
    req0_sec_read = 1'b1; req0_sec_read_addr = 32'h100;
    req1_sec_read = 1'b1; req1_sec_read_addr = 32'h200;
    for (int k = 0; k < 6; k++) push_exp(k % 2, (k % 2) ? 32'h200 : 32'h100);
    for (int k = 0; k < 6; k++) begin
      wait_grant(k == 0 ? 0 : 1);
      stream(4);
      finish_end();
    end
    req0_sec_read = 1'b0; req1_sec_read = 1'b0;

    // Back-to-back sectors on one port with advancing addresses.
    req0_sec_read = 1'b1; req0_sec_read_addr = 32'd100;
    for (int k = 0; k < 3; k++) push_exp(0, 32'd100 + 32'(k));
    for (int k = 0; k < 3; k++) begin
      wait_grant(k == 0 ? -1 : 1);
      stream(3);
      finish_end();
      req0_sec_read_addr = req0_sec_read_addr + 32'd1;
    end
    req0_sec_read = 1'b0;

    // End arriving on the watchdog limit cycle is a normal end.
    req0_sec_read = 1'b1; req0_sec_read_addr = 32'd200;
    push_exp(0, 32'd200);
    wait_grant(-1);
    stream(int'(TO) - 1);
    finish_end();
    req0_sec_read = 1'b0;

    // Watchdog abort on port 1, then port 0 must win the next contest.
    req1_sec_read = 1'b1; req1_sec_read_addr = 32'd77;
    push_exp(1, 32'd77);
    wait_grant(-1);
    watchdog_abort();
    req0_sec_read = 1'b1; req0_sec_read_addr = 32'd300;
    push_exp(0, 32'd300);
    push_exp(1, 32'd77);
    wait_grant(1);
    stream(2);
    finish_end();
    req0_sec_read = 1'b0;
    wait_grant(1);
    stream(2);
    finish_end();
    req1_sec_read = 1'b0;

    // sd_init_done drop mid-grant on port 0: silent abort, fairness kept.
    req0_sec_read = 1'b1; req0_sec_read_addr = 32'd500;
    push_exp(0, 32'd500);
    wait_grant(-1);
    stream(3);
    sd_init_done = 1'b0;
    #1;
    check("initlo_no_end", req0_sec_read_end, 0);
    @(negedge clk);
    check("initlo_sd_read", sd_sec_read, 0);
    check("initlo_grant", grant, 0);
    check("initlo_no_end2", req0_sec_read_end, 0);
    @(negedge clk);
    check("initlo_held", sd_sec_read, 0);
    req1_sec_read = 1'b1; req1_sec_read_addr = 32'd600;
    push_exp(0, 32'd500);
    push_exp(1, 32'd600);
    sd_init_done = 1'b1;
    wait_grant(0);
    stream(2);
    finish_end();
    req0_sec_read = 1'b0;
    wait_grant(1);
    stream(2);
    finish_end();
    req1_sec_read = 1'b0;

    // Async reset mid-grant restores port-0 priority.
    req0_sec_read = 1'b1; req0_sec_read_addr = 32'd900;
    push_exp(0, 32'd900);
    wait_grant(-1);
    stream(1);
    finish_end();
    req0_sec_read = 1'b0;
    req1_sec_read = 1'b1; req1_sec_read_addr = 32'd901;
    push_exp(1, 32'd901);
    wait_grant(1);
    stream(2);
    sd_sec_read_data = 8'hFF;
    sd_sec_read_data_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("arst_sd_read", sd_sec_read, 0);
    check("arst_grant", grant, 0);
    check("arst_valid", req1_sec_read_data_valid, 0);
    check("arst_data", req1_sec_read_data, 0);
    @(negedge clk);
    rst = 1'b0;
    sd_sec_read_data_valid = 1'b0;
    req0_sec_read = 1'b1; req0_sec_read_addr = 32'd902;
    push_exp(0, 32'd902);
    push_exp(1, 32'd901);
    wait_grant(0);
    stream(1);
    finish_end();
    req0_sec_read = 1'b0;
    wait_grant(1);
    stream(1);
    finish_end();
    req1_sec_read = 1'b0;

    check("sb_drained", exp_port_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_sec_read_arbiter.md
# sd_sec_read_arbiter

Two-port arbiter that shares the single SD-card sector-read engine between two sector-read requesters (accompaniment WAV reader on port 0, secondary track/lyrics reader on port 1). It sits between the requesters and the SD controller. It serialises whole-sector transactions with round-robin fairness and routes read data, valid and end strobes back only to the granted requester. A watchdog releases the engine if a sector read never completes.

## Interface
- TIMEOUT_CYCLES, 32'd5_000_000: cycles a granted transaction may stay open before it is aborted (100 ms at 50 MHz); must be ≥ 2.
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- sd_init_done  in  1  SD card initialised; low forces idle
- req0_sec_read / req1_sec_read  in  1  level request; held high until the requester sees its end strobe
- req0_sec_read_addr / req1_sec_read_addr  in  32  sector address; sampled at grant
- req0_sec_read_data / req1_sec_read_data  out  8  routed read data; 0 when not granted
- req0_sec_read_data_valid / req1_sec_read_data_valid  out  1  routed data valid
- req0_sec_read_end / req1_sec_read_end  out  1  routed (or synthetic) end strobe
- sd_sec_read  out  1  request to the SD controller
- sd_sec_read_addr  out  32  latched sector address
- sd_sec_read_data  in  8  SD controller read data
- sd_sec_read_data_valid  in  1  SD controller data valid
- sd_sec_read_end  in  1  SD controller sector done
- grant  out  2  one-hot owner; bit n set = port n owns the engine
- timeout_err  out  1  one-cycle pulse on watchdog abort

## Operation
- States: IDLE, GRANT, GAP.
- IDLE:
  - If any reqN_sec_read=1 and sd_init_done=1, pick a winner and go to GRANT.
  - On the same edge: grant<=winner, sd_sec_read<=1, sd_sec_read_addr<=winner's addr, watchdog<=0.
- Round robin:
  - last_grant register, reset value 1, so port 0 wins first.
  - If both ports request, the port ≠ last_grant wins; if one requests, it wins.
  - last_grant is updated when GRANT is left.
- GRANT:
  - sd_sec_read held 1; sd_sec_read_addr stable; watchdog increments each cycle.
  - On sd_sec_read_end=1, go to GAP: sd_sec_read<=0, grant<=0.
  - Else, if watchdog==TIMEOUT_CYCLES-1, go to GAP with the same register updates, plus timeout_err=1 for one cycle and a synthetic end to the owner.
- GAP: one cycle with sd_sec_read=0, so the controller sees a fresh request edge; then go to IDLE.
- Routing (combinational, gated by grant):
  - reqN_sec_read_data = grant[N] ? sd_sec_read_data : 0.
  - reqN_sec_read_data_valid = grant[N] & sd_sec_read_data_valid.
  - reqN_sec_read_end = grant[N] & (sd_sec_read_end | timeout_hit).
- A requester dropping its request during GRANT does not abort the transaction; data is still routed until end.
- A requester that keeps its request high after its end strobe is treated as a new request in IDLE and arbitrated normally. Its address is sampled then, so an address updated on the end cycle is honoured.

## Timing
- Reset values:
  - State IDLE; last_grant=1; watchdog=0.
  - sd_sec_read=0, sd_sec_read_addr=0, grant=2'b00, timeout_err=0.
  - All reqN outputs 0.
- Grant latency: request visible in IDLE at cycle T → grant and sd_sec_read high at T+1.
- Release: end at cycle T (routed to the owner in cycle T) → sd_sec_read=0, grant=0 at T+1 (GAP) → IDLE at T+2 → next grant at T+3 at the earliest.
- sd_sec_read_end and the watchdog limit in the same cycle: treated as a normal end; no timeout_err.
- sd_sec_read_data_valid or sd_sec_read_end in IDLE or GAP: ignored, not routed.
- sd_init_done low in any state: on the next edge, state=IDLE, sd_sec_read=0, grant=0, watchdog=0. last_grant is unchanged. No end strobe is issued to the aborted owner.
- Watchdog: 32-bit, cleared on entering GRANT, saturates; never counts outside GRANT.

## Test plan
- Single requester: req0 high, addr0=8196 → grant=01 and sd_sec_read=1 one cycle later, sd_sec_read_addr=8196. 512 valid bytes appear only on req0 data; req1 outputs stay 0. End → GAP, then idle.
- Simultaneous requests after reset: req0 and req1 both high → port 0 granted first. After its end, port 1 granted at end+3 cycles. If both remain high, grants alternate 01,10,01 for 6 sectors.
- Back-to-back same port: req0 held high, address advances by +1 on each end → consecutive grants carry sequential addresses; sd_sec_read is low for exactly 2 cycles between sectors.
- Watchdog: TIMEOUT_CYCLES=16, grant port 1, no end from the controller → at cycle 16 of GRANT, timeout_err and req1_sec_read_end pulse together for 1 cycle. sd_sec_read drops the next cycle; last_grant=1.
- sd_init_done drop: deassert mid-GRANT on port 0 → next cycle sd_sec_read=0, grant=00, no end to port 0. Re-assert → fresh arbitration with port 0 still favoured over port 1.
- Async reset mid-GRANT: rst pulse → all outputs 0 immediately, and port 0 is favoured on the next contest.
